// File: rtl/spi_buf_pkg.sv
// Shared types, default sizes and the frame-length check for the
// ping-pong SPI transmit buffer.
package spi_buf_pkg;

    // Occupancy of one buffer bank.
    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_e;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_AW = 11;

    // A frame must hold at least one word and no more than one bank.
    function automatic logic len_ok(input logic [31:0] wlen, input int unsigned aw);
        return (wlen != 32'd0) && (wlen <= (32'd1 << aw));
    endfunction

endpackage

// File: rtl/spi_bram_sdp.sv
// Simple dual-port RAM holding both banks: one write port and one read
// port with a registered output. The array has no reset so it maps onto
// block RAM; only the output register is cleared.
module spi_bram_sdp
    import spi_buf_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW:0]   i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW:0]   i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**(AW+1))-1];
    logic [DW-1:0] r_rdata;

    // Write port: store the word at the write edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered output, cleared by reset, held between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_bram_pingpong_out.sv
// Two-bank ping-pong transmit buffer. The writer fills the current bank by
// address and commits it with a length; the reader drains committed banks
// in order, one word per pop, flagging the last word of each frame.
module spi_bram_pingpong_out
    import spi_buf_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_wcommit,
    input  logic [AW:0]   i_wlen,
    output logic          o_wready,
    input  logic          i_ren,
    output logic          o_not_empty,
    output logic          o_rvalid,
    output logic [DW-1:0] o_rdata,
    output logic          o_rlast,
    output logic          o_err
);

    bank_state_e r_state [2];
    logic [AW:0] r_len   [2];
    logic        r_wb;
    logic        r_rb;
    logic [AW:0] r_rptr;
    logic        r_rvalid;
    logic        r_rlast;
    logic        r_err;

    logic w_wready;
    logic w_not_empty;
    logic w_len_ok;
    logic w_wr;
    logic w_commit;
    logic w_pop;
    logic w_pop_last;
    logic w_err_set;

    assign w_wready    = (r_state[r_wb] == BANK_FREE);
    assign w_not_empty = (r_state[r_rb] == BANK_FULL);
    assign w_len_ok    = len_ok(32'(i_wlen), AW);
    assign w_wr        = i_wen && w_wready;
    assign w_commit    = i_wcommit && w_wready && w_len_ok;
    assign w_pop       = i_ren && w_not_empty;
    assign w_pop_last  = w_pop && (r_rptr == (r_len[r_rb] - (AW+1)'(1)));
    // Any access to a busy bank, or a commit with an impossible length.
    assign w_err_set   = ((i_wen || i_wcommit) && !w_wready)
                       || (i_wcommit && w_wready && !w_len_ok);

    // Bank ownership: a commit fills the write bank, a last-word pop frees
    // the read bank. Both can happen in one cycle because they never
    // target the same bank (one needs FREE, the other FULL).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state[0] <= BANK_FREE;
            r_state[1] <= BANK_FREE;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
        end else begin
            if (w_commit) begin
                r_state[r_wb] <= BANK_FULL;
                r_len[r_wb]   <= i_wlen;
                r_wb          <= ~r_wb;
            end
            if (w_pop_last) begin
                r_state[r_rb] <= BANK_FREE;
                r_rb          <= ~r_rb;
            end
        end
    end

    // Read offset inside the current read bank; wraps to 0 on the last word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rptr <= '0;
        end else if (w_pop_last) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Output strobes line up with the registered RAM read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            r_rvalid <= w_pop;
            r_rlast  <= w_pop_last;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    spi_bram_sdp #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_wr),
        .i_waddr ({r_wb, i_waddr}),
        .i_wdata (i_wdata),
        .i_re    (w_pop),
        .i_raddr ({r_rb, r_rptr[AW-1:0]}),
        .o_rdata (o_rdata)
    );

    assign o_wready    = w_wready;
    assign o_not_empty = w_not_empty;
    assign o_rvalid    = r_rvalid;
    assign o_rlast     = r_rlast;
    assign o_err       = r_err;

endmodule

// File: tb/tb_spi_bram_pingpong_out.sv
// Directed bench for the ping-pong transmit buffer. A behavioural model
// tracks committed frames as a word stream; pops push the expected word
// onto a scoreboard that is popped when the DUT presents rvalid.
module tb_spi_bram_pingpong_out;

    localparam int DW    = 8;
    localparam int AW    = 11;
    localparam int DEPTH = 2**AW;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wcommit;
    logic [AW:0]   wlen;
    logic          wready;
    logic          ren;
    logic          not_empty;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          err;

    word_t         frame_q[$];
    word_t         sb_q[$];
    logic [DW-1:0] m_mem [0:2*DEPTH-1];
    int            m_frames;
    logic          m_wb;
    logic          m_err;
    int            n_tests;
    int            n_fail;

    always #5 clk = ~clk;

    spi_bram_pingpong_out #(.DW(DW), .AW(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wen       (wen),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wcommit   (wcommit),
        .i_wlen      (wlen),
        .o_wready    (wready),
        .i_ren       (ren),
        .o_not_empty (not_empty),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_rlast     (rlast),
        .o_err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus with model update and output checks.
    task automatic cyc(input logic c_wen, input logic [AW-1:0] c_addr, input logic [DW-1:0] c_data,
                       input logic c_commit, input logic [AW:0] c_len, input logic c_ren);
        logic  wr_ok;
        logic  pop_ok;
        logic  pop_last;
        word_t w;
        wen     = c_wen;
        waddr   = c_addr;
        wdata   = c_data;
        wcommit = c_commit;
        wlen    = c_len;
        ren     = c_ren;
        wr_ok    = (m_frames < 2);
        pop_ok   = c_ren && (m_frames > 0);
        pop_last = 1'b0;
        if (pop_ok) begin
            w = frame_q.pop_front();
            pop_last = w.last;
            sb_q.push_back(w);
        end
        if ((c_wen || c_commit) && !wr_ok) m_err = 1'b1;
        if (c_wen && wr_ok) m_mem[{m_wb, c_addr}] = c_data;
        if (c_commit && wr_ok) begin
            if (c_len == 0 || int'(c_len) > DEPTH) begin
                m_err = 1'b1;
            end else begin
                for (int i = 0; i < int'(c_len); i++) begin
                    w.last = (i == int'(c_len) - 1);
                    w.data = m_mem[{m_wb, i[AW-1:0]}];
                    frame_q.push_back(w);
                end
                m_frames++;
                m_wb = ~m_wb;
            end
        end
        if (pop_last) m_frames--;
        @(posedge clk);
        #1;
        chk("rvalid", 32'(rvalid), 32'(pop_ok));
        if (pop_ok && sb_q.size() > 0) begin
            w = sb_q.pop_front();
            chk("rdata", 32'(rdata), 32'(w.data));
            chk("rlast", 32'(rlast), 32'(w.last));
        end
        chk("wready", 32'(wready), 32'(m_frames < 2));
        chk("not_empty", 32'(not_empty), 32'(m_frames > 0));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(1'b1, a, d, 1'b0, 12'd0, 1'b0);
    endtask

    task automatic commit(input logic [AW:0] l);
        cyc(1'b0, 11'd0, 8'd0, 1'b1, l, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 11'd0, 8'd0, 1'b0, 12'd0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 11'd0, 8'd0, 1'b0, 12'd0, 1'b0);
    endtask

    // One-cycle reset, then the required post-reset output values.
    task automatic do_reset();
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        wcommit = 1'b0; wlen = '0; ren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_frames = 0; m_wb = 1'b0; m_err = 1'b0;
        frame_q.delete();
        sb_q.delete();
        chk("rst_not_empty", 32'(not_empty), 32'd0);
        chk("rst_wready", 32'(wready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        wcommit = 1'b0; wlen = '0; ren = 1'b0;
        m_frames = 0; m_wb = 1'b0; m_err = 1'b0;
        @(posedge clk);
        do_reset();

        // Basic frame
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(i));
        commit(12'd4);
        for (int i = 0; i < 4; i++) pop();
        idle();

        // Ping-pong, write and commit together on the last word of A
        wr(11'd0, 8'hAA);
        cyc(1'b1, 11'd1, 8'hAB, 1'b1, 12'd2, 1'b0);
        wr(11'd0, 8'hB0);
        wr(11'd1, 8'hB1);
        wr(11'd2, 8'hB2);
        commit(12'd3);
        for (int i = 0; i < 6; i++) pop();
        idle();

        // Last-word pop and commit of the other bank in one cycle
        wr(11'd0, 8'h31);
        commit(12'd1);
        wr(11'd0, 8'h32);
        cyc(1'b0, 11'd0, 8'd0, 1'b1, 12'd1, 1'b1);
        pop();
        idle();

        // Blocked write and commit
        do_reset();
        wr(11'd0, 8'h11);
        commit(12'd1);
        wr(11'd0, 8'h22);
        commit(12'd1);
        cyc(1'b1, 11'd0, 8'h55, 1'b1, 12'd1, 1'b0);
        idle();
        pop();
        pop();
        idle();

        // Illegal lengths
        do_reset();
        commit(12'd0);
        idle();
        do_reset();
        commit(12'(DEPTH + 1));
        wr(11'd0, 8'h77);
        commit(12'd1);
        pop();
        idle();

        // Full-depth frame
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), i[DW-1:0]);
        commit(12'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop();
        idle();
        wr(11'd0, 8'h5A);
        commit(12'd1);
        pop();
        idle();

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 4; i++) wr(AW'(i), 8'hC0 + DW'(i));
        commit(12'd4);
        pop();
        pop();
        do_reset();
        wr(11'd0, 8'hD0);
        wr(11'd1, 8'hD1);
        commit(12'd2);
        pop();
        pop();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
